// File: rtl/pipe_sched_pkg.sv
// Shared types and width helpers for the pipelined issue scheduler.
package pipe_sched_pkg;

  // Widest tag carried through the tracking stages (up to 16 requesters).
  localparam int MAX_TAG_W = 4;

  // ceil(log2(n)), never below 1; sizes both the tag and the credit counter.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // One tracking stage: token present plus the requester it belongs to.
  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
  } stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, with wrap.
module rr_arbiter
  import pipe_sched_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan requesters starting at ptr and grant the first one found.
  always_comb begin
    int          pos;
    logic [W-1:0] j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      j = W'(pos);
      if (en && !any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_issue_sched.sv
// Credit-limited round-robin issue scheduler feeding a fixed-latency shift pipeline.
// Tokens carry the requester index so completions can be steered back.
module pipe_issue_sched
  import pipe_sched_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int LATENCY      = 5,
  parameter  int MAX_INFLIGHT = 1,
  localparam int TAG_W        = clog2_min1(NUM_REQ),
  localparam int CNT_W        = clog2_min1(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               issue_valid,
  output logic [TAG_W-1:0]   issue_tag,
  output logic               done_valid,
  output logic [TAG_W-1:0]   done_tag,
  output logic [CNT_W-1:0]   inflight,
  output logic               full
);

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  stage_t           stage_q [LATENCY];
  stage_t           stage_d [LATENCY];
  logic             issue_en;
  logic             arb_any;
  logic [TAG_W-1:0] arb_idx;
  logic             unused_tag_hi;

  // Credit check uses only the registered count, so a completion this cycle
  // cannot enable a grant in the same cycle.
  assign issue_en = rst && (inflight_q < CNT_W'(MAX_INFLIGHT));

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .en  (issue_en),
    .gnt (gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign issue_valid = arb_any;
  assign issue_tag   = arb_idx;
  // Completions are suppressed while reset is held so flushed tokens never report.
  assign done_valid  = rst && stage_q[LATENCY-1].valid;
  assign done_tag    = stage_q[LATENCY-1].tag[TAG_W-1:0];
  assign inflight    = inflight_q;
  assign full        = rst && (inflight_q == CNT_W'(MAX_INFLIGHT));
  // Tag bits above TAG_W ride along in the shared stage record but are never read.
  assign unused_tag_hi = ^stage_q[LATENCY-1].tag;

  // Next pointer, credit count and shifted tracking stages.
  always_comb begin
    ptr_d      = ptr_q;
    inflight_d = inflight_q + CNT_W'(issue_valid) - CNT_W'(done_valid);
    for (int s = 0; s < LATENCY; s++) stage_d[s] = '0;
    if (arb_any) begin
      ptr_d = (arb_idx == TAG_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end
    stage_d[0].valid = issue_valid;
    stage_d[0].tag   = MAX_TAG_W'(issue_tag);
    for (int s = 1; s < LATENCY; s++) stage_d[s] = stage_q[s-1];
  end

  // Register control state with reset; stage tags are data and never reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      for (int s = 0; s < LATENCY; s++) stage_q[s].valid <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      for (int s = 0; s < LATENCY; s++) stage_q[s].valid <= stage_d[s].valid;
    end
    for (int s = 0; s < LATENCY; s++) stage_q[s].tag <= stage_d[s].tag;
  end

endmodule
